// File: rtl/clk_period_meter.sv
// clk_period_meter: measures the period and high time of a slow, divided clock
// (clk_in) in cycles of the system clock. clk_in is synchronized, its edges are
// detected, and an IDLE/ARM/HIGH/LOW FSM runs back-to-back measurements. The
// result is held behind a valid/ready handshake. Sticky flags report dropped
// results (overrun) and counter saturation (sat). stuck reports a clk_in that
// has stopped toggling.
module clk_period_meter #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_in,
    input  logic             en,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic             overrun,
    output logic             sat,
    output logic             stuck
);

    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [IDLE_W-1:0] IDLE_TOP = IDLE_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;

    state_t             state_reg, state_next;
    logic               sync1_reg, sync2_reg, edge_reg;
    logic               en_d_reg;
    logic [CNT_W-1:0]   per_cnt_reg, high_cnt_reg;
    logic [IDLE_W-1:0]  idle_cnt_reg;
    logic [CNT_W-1:0]   period_reg, high_time_reg;
    logic               valid_reg, overrun_reg, sat_reg;

    logic rise, fall;
    logic start, complete, count_per, count_high, sat_set;
    logic accept, en_rise;

    // Two-flop synchronizer plus an edge register for clk_in.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            edge_reg  <= 1'b0;
        end else begin
            sync1_reg <= clk_in;
            sync2_reg <= sync1_reg;
            edge_reg  <= sync2_reg;
        end
    end

    assign rise    = sync2_reg & ~edge_reg;
    assign fall    = ~sync2_reg & edge_reg;
    assign stuck   = (idle_cnt_reg == IDLE_TOP);
    assign accept  = valid_reg & meas_ready;
    assign en_rise = en & ~en_d_reg;

    // FSM state register and enable history for detecting a fresh enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            en_d_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            en_d_reg  <= en;
        end
    end

    // Next-state logic; also decides which counters advance this cycle.
    always_comb begin
        state_next = state_reg;
        start      = 1'b0;
        complete   = 1'b0;
        count_per  = 1'b0;
        count_high = 1'b0;
        if (!en) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: state_next = ARM;
                ARM: begin
                    if (rise) begin
                        state_next = HIGH;
                        start      = 1'b1;
                    end
                end
                HIGH: begin
                    if (stuck) begin
                        state_next = ARM;
                    end else begin
                        // A rise here cannot follow a clean synchronized
                        // waveform, so it is simply not acted on.
                        count_per = 1'b1;
                        if (fall) state_next = LOW;
                        else      count_high = 1'b1;
                    end
                end
                LOW: begin
                    if (stuck) begin
                        state_next = ARM;
                    end else if (rise) begin
                        state_next = HIGH;
                        start      = 1'b1;
                        complete   = 1'b1;
                    end else begin
                        count_per = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign sat_set = (count_per && per_cnt_reg == CNT_MAX) ||
                     (count_high && high_cnt_reg == CNT_MAX);

    // Period and high-time counters: restart at 1 on a measured rise and
    // hold at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            per_cnt_reg  <= '0;
            high_cnt_reg <= '0;
        end else if (start) begin
            per_cnt_reg  <= CNT_W'(1);
            high_cnt_reg <= CNT_W'(1);
        end else begin
            if (count_per && per_cnt_reg != CNT_MAX)
                per_cnt_reg <= per_cnt_reg + 1'b1;
            if (count_high && high_cnt_reg != CNT_MAX)
                high_cnt_reg <= high_cnt_reg + 1'b1;
        end
    end

    // Idle counter: cleared by any clk_in edge, advances only while enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt_reg <= '0;
        end else if (rise || fall) begin
            idle_cnt_reg <= '0;
        end else if (en && idle_cnt_reg != IDLE_TOP) begin
            idle_cnt_reg <= idle_cnt_reg + 1'b1;
        end
    end

    // Held result with handshake, plus the sticky overrun and sat flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            period_reg    <= '0;
            high_time_reg <= '0;
            valid_reg     <= 1'b0;
            overrun_reg   <= 1'b0;
            sat_reg       <= 1'b0;
        end else begin
            if (en_rise) begin
                overrun_reg <= 1'b0;
                sat_reg     <= 1'b0;
            end else begin
                if (sat_set)
                    sat_reg <= 1'b1;
                if (complete && valid_reg && !meas_ready)
                    overrun_reg <= 1'b1;
            end
            if (complete && (!valid_reg || accept)) begin
                period_reg    <= per_cnt_reg;
                high_time_reg <= high_cnt_reg;
                valid_reg     <= 1'b1;
            end else if (accept) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign period     = period_reg;
    assign high_time  = high_time_reg;
    assign meas_valid = valid_reg;
    assign overrun    = overrun_reg;
    assign sat        = sat_reg;

endmodule

// File: tb/tb_clk_period_meter.sv
// Bench for clk_period_meter: directed scenarios with literal expectations,
// then randomized clk_in waveforms, handshakes, enable drops and resets, all
// compared every cycle against a timestamp-based measurement model.
module tb_clk_period_meter;

    localparam int CW   = 16;
    localparam int TO   = 1024;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst, clk_in, en, meas_ready;
    logic [CW-1:0] period, high_time;
    logic          meas_valid, overrun, sat, stuck;

    logic          clk_in2, en2, ready2;
    logic [3:0]    period2, high_time2;
    logic          valid2, overrun2, sat2, stuck2;

    int tests  = 0;
    int failed = 0;

    clk_period_meter #(.CNT_W(CW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .clk_in(clk_in), .en(en),
        .period(period), .high_time(high_time), .meas_valid(meas_valid),
        .meas_ready(meas_ready), .overrun(overrun), .sat(sat), .stuck(stuck)
    );

    clk_period_meter #(.CNT_W(4), .TIMEOUT(64)) dut_small (
        .clk(clk), .rst(rst), .clk_in(clk_in2), .en(en2),
        .period(period2), .high_time(high_time2), .meas_valid(valid2),
        .meas_ready(ready2), .overrun(overrun2), .sat(sat2), .stuck(stuck2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Works on the clk_in value seen at each clk edge. Edges become visible to
    // the measurement three samples late; measurements are computed from the
    // edge-index timestamps of rise/fall/rise.
    localparam int P_IDLE = 0, P_ARM = 1, P_HIGH = 2, P_LOW = 3;
    int k = 0, last_rise = 0, fall_t = 0, idle_n = 0, phase = P_IDLE;
    bit h1, h2, h3, en_prev, started = 0;
    bit m_valid, m_ovr, m_sat;
    int m_per, m_ht;

    initial begin
        forever begin
            @(posedge clk);
            k++;
            if (rst) begin
                h1 = 0; h2 = 0; h3 = 0; en_prev = 0; phase = P_IDLE; idle_n = 0;
                m_valid = 0; m_ovr = 0; m_sat = 0; m_per = 0; m_ht = 0;
                started = 1;
            end else begin
                bit r, f, st, acc, done;
                int np, nh;
                r = h2 & !h3;
                f = !h2 & h3;
                st = (idle_n == TO);
                acc = m_valid && meas_ready;
                done = 0; np = 0; nh = 0;
                if (en && !en_prev) begin m_ovr = 0; m_sat = 0; end
                if (!en) phase = P_IDLE;
                else if (phase == P_IDLE) phase = P_ARM;
                else if (st && phase != P_ARM) phase = P_ARM;
                else begin
                    case (phase)
                        P_ARM: if (r) begin last_rise = k; phase = P_HIGH; end
                        P_HIGH: begin
                            if (k - last_rise >= CMAX) m_sat = 1;
                            if (f) begin fall_t = k; phase = P_LOW; end
                        end
                        default: begin
                            if (r) begin
                                done = 1;
                                np = (k - last_rise > CMAX) ? CMAX : k - last_rise;
                                nh = (fall_t - last_rise > CMAX) ? CMAX : fall_t - last_rise;
                                last_rise = k;
                                phase = P_HIGH;
                            end else if (k - last_rise >= CMAX) m_sat = 1;
                        end
                    endcase
                end
                if (done) begin
                    if (!m_valid || acc) begin m_per = np; m_ht = nh; m_valid = 1; end
                    else m_ovr = 1;
                end else if (acc) m_valid = 0;
                if (r || f) idle_n = 0;
                else if (en && idle_n < TO) idle_n++;
                en_prev = en;
                h3 = h2; h2 = h1; h1 = clk_in;
            end
        end
    end

    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                chk("valid", meas_valid, m_valid);
                chk("period", period, m_per);
                chk("high_time", high_time, m_ht);
                chk("overrun", overrun, m_ovr);
                chk("sat", sat, m_sat);
                chk("stuck", stuck, (idle_n == TO));
            end
        end
    end

    // ---------------- stimulus ----------------
    int wave_hi = 0, wave_lo = 2, wave_pos = 0;

    task automatic tick();
        if (wave_hi == 0) clk_in = 1'b0;
        else begin
            clk_in = (wave_pos < wave_hi);
            wave_pos++;
            if (wave_pos >= wave_hi + wave_lo) wave_pos = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_valid(input string name, input int budget);
        int i;
        i = 0;
        while (!meas_valid && i < budget) begin tick(); i++; end
        if (!meas_valid) chk(name, 0, 1);
    endtask

    // Small-width instance: clk_in2 high 20 / low 20 cycles.
    initial begin
        int c2;
        c2 = 0; clk_in2 = 1'b0; en2 = 1'b1; ready2 = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            c2 = (c2 + 1) % 40;
            clk_in2 = (c2 < 20);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int en_off;
        rst = 1; en = 0; meas_ready = 1; clk_in = 0;
        ticks(3);
        chk("rst_period", period, 0);
        chk("rst_high", high_time, 0);
        chk("rst_valid", meas_valid, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_stuck", stuck, 0);

        // 3 high / 2 low, always ready
        rst = 0; en = 1;
        wave_hi = 3; wave_lo = 2; wave_pos = 0;
        ticks(40);
        wait_valid("wait_first", 12);
        chk("lit_period", period, 5);
        chk("lit_high", high_time, 3);
        chk("model_period", m_per, 5);
        chk("model_high", m_ht, 3);

        // Consumer stalls: result held, later completion is dropped
        meas_ready = 0;
        wait_valid("wait_hold", 12);
        ticks(12);
        chk("hold_valid", meas_valid, 1);
        chk("hold_overrun", overrun, 1);
        chk("hold_period", period, 5);
        meas_ready = 1;
        tick();

        // clk_in stops: stuck after TIMEOUT cycles, clears on next rise
        wave_hi = 0;
        ticks(TO + 10);
        chk("stuck_set", stuck, 1);
        wave_hi = 3; wave_lo = 2; wave_pos = 0;
        ticks(5);
        chk("stuck_clear", stuck, 0);
        wait_valid("wait_after_stuck", 10);
        chk("after_stuck_period", period, 5);

        // Reset in LOW phase
        ticks(7);
        wave_hi = 0;
        ticks(5);
        rst = 1;
        tick();
        chk("mid_rst_valid", meas_valid, 0);
        chk("mid_rst_period", period, 0);
        chk("mid_rst_high", high_time, 0);
        chk("mid_rst_overrun", overrun, 0);
        chk("mid_rst_sat", sat, 0);
        rst = 0;
        wave_hi = 3; wave_lo = 2; wave_pos = 0;
        ticks(4);
        chk("mid_rst_no_pulse", meas_valid, 0);

        // Enable drop while HIGH clears sticky flags
        meas_ready = 0;
        ticks(20);
        chk("pre_en_overrun", overrun, 1);
        wave_pos = 0;
        ticks(4);
        en = 0;
        ticks(2);
        en = 1;
        tick();
        chk("en_overrun_clr", overrun, 0);
        chk("en_sat_clr", sat, 0);
        meas_ready = 1;
        ticks(100);

        // Small instance saturation
        chk("small_period", period2, 15);
        chk("small_high", high_time2, 15);
        chk("small_sat", sat2, 1);

        // Randomized phase
        en_off = 0;
        for (int i = 0; i < 5000; i++) begin
            if (wave_pos == 0 && $urandom_range(0, 3) == 0) begin
                wave_hi = $urandom_range(1, 12);
                wave_lo = $urandom_range(1, 12);
            end
            meas_ready = ($urandom_range(0, 2) != 0);
            if (en_off > 0) begin
                en_off--;
                if (en_off == 0) en = 1;
            end else if ($urandom_range(0, 249) == 0) begin
                en = 0;
                en_off = $urandom_range(1, 3);
            end
            rst = ($urandom_range(0, 799) == 0);
            tick();
        end
        rst = 0;
        ticks(2);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/clk_period_meter.md
CLK_PERIOD_METER -- requirements
Module: clk_period_meter

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the width of the period and high-time counters and results.
REQ-002 The block SHALL have parameter TIMEOUT, default 1024, giving the number of clk cycles without a detected clk_in edge before stuck is flagged.
REQ-003 clk  input  1  system clock; all state on posedge clk.
REQ-004 rst  input  1  reset: synchronous, active-high.
REQ-005 clk_in  input  1  divided clock under measurement, asynchronous to clk.
REQ-006 en  input  1  measurement enable.
REQ-007 period  output  CNT_W  clk cycles between two successive detected rising edges of clk_in.
REQ-008 high_time  output  CNT_W  clk cycles from a detected rising edge to the next detected falling edge.
REQ-009 meas_valid  output  1  result valid; held until accepted.
REQ-010 meas_ready  input  1  consumer accepts the result when meas_valid && meas_ready.
REQ-011 overrun  output  1  sticky: a completed measurement was dropped.
REQ-012 sat  output  1  sticky: a counter saturated during a measurement.
REQ-013 stuck  output  1  clk_in has shown no edge for TIMEOUT cycles.

Function
REQ-014 clk_in SHALL pass through a 2-flop synchronizer followed by one edge register; rise/fall detect pulses SHALL be one clk cycle wide and occur 3 clk cycles after clk_in changes, when clk_in is sampled cleanly.
REQ-015 FSM states SHALL be IDLE, ARM, HIGH and LOW.
REQ-016 IDLE->ARM when en=1; any state->IDLE when en=0, discarding any partial measurement but not the held result.
REQ-017 ARM->HIGH on rise; entering HIGH SHALL clear both counters to 1.
REQ-018 In HIGH, a fall SHALL latch the high counter and move to LOW; the period counter SHALL continue counting.
REQ-019 In LOW, a rise SHALL complete the measurement, load period and high_time, re-clear the counters to 1, and remain a new HIGH phase with back-to-back measurement and no gap.
REQ-020 In HIGH, a rise without an intervening fall is impossible after synchronization and SHALL be ignored.
REQ-021 meas_valid SHALL assert the cycle after the completing rise and SHALL stay asserted, with period/high_time stable, until the accepting handshake.
REQ-022 If a measurement completes while meas_valid=1 and meas_ready=0, the new result SHALL be dropped and overrun SHALL be set.
REQ-023 If a measurement completes in the same cycle as the accepting handshake, the new result SHALL be loaded, meas_valid SHALL remain 1, and overrun SHALL stay unchanged.
REQ-024 Counters SHALL saturate at all-ones without wrapping, and saturation SHALL set sat.
REQ-025 overrun and sat SHALL clear only on rst or on an en 0->1 transition.
REQ-026 An idle counter SHALL reset on every detected edge; it SHALL count only while en=1.
REQ-027 stuck SHALL set when the idle counter reaches TIMEOUT and SHALL clear on the next detected edge.
REQ-028 While stuck=1, the FSM SHALL return to ARM.

Reset
REQ-029 On rst: state SHALL be IDLE; synchronizer, edge and counter registers SHALL be 0; period=0, high_time=0, and meas_valid, overrun, sat and stuck SHALL all be 0.
REQ-030 rst mid-measurement SHALL discard all partial and held results, with no meas_valid pulse afterwards.

Verification
REQ-031 Drive clk_in synchronously to clk with high 3 / low 2 cycles, en=1, meas_ready=1 -> the first meas_valid gives period=5, high_time=3, and every following 5 cycles give the same values.
REQ-032 Use the same stimulus with meas_ready=0 -> the first result is held unchanged, the second completion sets overrun=1, and raising meas_ready accepts period=5.
REQ-033 Hold clk_in=0 for 1024 cycles with TIMEOUT=1024 -> stuck=1; a later rise gives stuck=0, and a valid result arrives one full period later.
REQ-034 Set CNT_W=4 with clk_in high 20 / low 20 -> period=15, high_time=15, sat=1.
REQ-035 Apply rst in LOW phase mid-measurement -> all outputs are 0 next cycle, and the next result requires a fresh rise, fall, rise sequence.
REQ-036 Deassert en in HIGH for 2 cycles, then reassert -> there is no partial result, overrun and sat are cleared, and the first result is valid after the rise, fall, rise sequence.
